// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave transfer block.
//   MODE0..MODE3  : {CPOL,CPHA} encodings of the four SPI modes
//   state_t       : frame state (IDLE / ACTIVE)
//   lead_is_rise  : which sclk edge opens a bit cell for a given CPOL
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // With CPOL=0 the clock idles low, so the first edge of a bit cell rises.
    function automatic logic lead_is_rise(input logic cpol);
        return ~cpol;
    endfunction

endpackage

// File: rtl/spi_slave_xfer_if.sv
// ---------------------------------------------------------------------------
// spi_slave_xfer_if
// Word-level streams between the SPI slave and the user logic.
//   tx_data/tx_valid/tx_ready : words to transmit (user -> slave)
//   rx_data/rx_valid/rx_ready : received words    (slave -> user)
// Modports:
//   slave  : the SPI slave side
//   master : the user logic side
// ---------------------------------------------------------------------------
interface spi_slave_xfer_if #(
    parameter int DATA_W = 32
) ();
    import spi_pkg::*;

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

endinterface

// File: rtl/spi_sync.sv
// ---------------------------------------------------------------------------
// spi_sync
// N-stage synchroniser for one asynchronous pin, with a configurable reset
// level so select lines can come out of reset deasserted.
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   i_d     : asynchronous input
//   o_q     : synchronised output (STAGES clocks of latency)
// ---------------------------------------------------------------------------
module spi_sync
    import spi_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Plain shift chain; the first flop may go metastable, the rest filter it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_sync <= {STAGES{RST_VAL}};
        else
            r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_slave_xfer.sv
// ---------------------------------------------------------------------------
// spi_slave_xfer
// Full-duplex SPI slave, all four modes, oversampled in the system clock.
// Ports:
//   clock, reset_n       : system clock / async active-low reset
//   sclk, ss_n, mosi     : asynchronous SPI pins
//   miso, miso_oeb       : SPI data out and its active-low output enable
//   mode                 : {CPOL,CPHA}, latched at frame start
//   bus (slave modport)  : tx and rx valid/ready word streams
//   busy                 : a frame is in progress
//   frame_abort          : pulse when ss_n rises mid-word
//   overrun              : sticky overrun flag
// Build option: define SPI_OVERRUN_DETECT_EN to drop words that arrive
// while the previous one is still unaccepted and raise a sticky overrun flag;
// otherwise the newer word overwrites and overrun is tied low.
// ---------------------------------------------------------------------------
module spi_slave_xfer
    import spi_pkg::*;
#(
    parameter int              DATA_W      = 32,
    parameter int              SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE   = {DATA_W{1'b1}}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sclk,
    input  logic             ss_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oeb,
    input  logic [1:0]       mode,
    spi_slave_xfer_if.slave  bus,
    output logic             busy,
    output logic             frame_abort,
    output logic             overrun
);

    localparam int CNT_W = $clog2(DATA_W);

    logic w_sclkS, w_ssS, w_mosiS;
    logic r_sclkD, r_ssD;
    logic w_sclkRise, w_sclkFall, w_ssFall, w_ssRise;
    logic w_leadEdge, w_trailEdge, w_sampleEdge, w_shiftEdge, w_lastBit;
    logic w_rxAccept;
    logic [DATA_W-1:0] w_txNext;

    state_t            r_state, w_stateNext;
    logic [1:0]        r_mode;
    logic [CNT_W-1:0]  r_bitCnt;
    logic [DATA_W-1:0] r_txShift, r_rxShift, r_rxData;
    logic              r_rxValid, r_txReady, r_frameAbort;
    logic              r_firstEdge, r_reloadPend, r_wordDone;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_syncSclk (
        .clock(clock), .reset_n(reset_n), .i_d(sclk), .o_q(w_sclkS));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_syncSs (
        .clock(clock), .reset_n(reset_n), .i_d(ss_n), .o_q(w_ssS));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_syncMosi (
        .clock(clock), .reset_n(reset_n), .i_d(mosi), .o_q(w_mosiS));

    // History flops: one cycle of delay so edges are seen as sample pairs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sclkD <= 1'b0;
            r_ssD   <= 1'b1;
        end else begin
            r_sclkD <= w_sclkS;
            r_ssD   <= w_ssS;
        end
    end

    assign w_sclkRise  = w_sclkS & ~r_sclkD;
    assign w_sclkFall  = ~w_sclkS & r_sclkD;
    assign w_ssFall    = ~w_ssS & r_ssD;
    assign w_ssRise    = w_ssS & ~r_ssD;
    assign w_leadEdge  = lead_is_rise(r_mode[1]) ? w_sclkRise : w_sclkFall;
    assign w_trailEdge = lead_is_rise(r_mode[1]) ? w_sclkFall : w_sclkRise;

    // A deselect wins over any clock edge seen in the same cycle.
    assign w_sampleEdge = (r_state == ACTIVE) && !w_ssRise &&
                          (r_mode[0] ? w_trailEdge : w_leadEdge);
    assign w_shiftEdge  = (r_state == ACTIVE) && !w_ssRise &&
                          (r_mode[0] ? w_leadEdge : w_trailEdge);
    assign w_lastBit    = (r_bitCnt == CNT_W'(DATA_W - 1));
    assign w_txNext     = bus.tx_valid ? bus.tx_data : TX_IDLE;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_stateNext;
    end

    // Next-state logic: frames are delimited purely by synced ss_n edges.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_ssFall) w_stateNext = ACTIVE;
            ACTIVE:  if (w_ssRise) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy     = (r_state == ACTIVE);
        miso_oeb = (r_state != ACTIVE);
    end

    // Bit engine: frame start/stop, receive shifting and transmit shifting.
    // In CPHA=1 the very first leading edge of a word must not shift, since
    // the MSB was already presented when the word was loaded.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mode       <= MODE0;
            r_bitCnt     <= '0;
            r_txShift    <= TX_IDLE;
            r_rxShift    <= '0;
            r_txReady    <= 1'b0;
            r_frameAbort <= 1'b0;
            r_firstEdge  <= 1'b0;
            r_reloadPend <= 1'b0;
            r_wordDone   <= 1'b0;
        end else begin
            r_txReady    <= 1'b0;
            r_frameAbort <= 1'b0;
            r_wordDone   <= 1'b0;
            if (r_state == IDLE && w_ssFall) begin
                r_mode       <= mode;
                r_bitCnt     <= '0;
                r_txShift    <= w_txNext;
                r_txReady    <= bus.tx_valid;
                r_firstEdge  <= 1'b1;
                r_reloadPend <= 1'b0;
            end else if (r_state == ACTIVE && w_ssRise) begin
                r_bitCnt     <= '0;
                r_frameAbort <= (r_bitCnt != '0);
                r_reloadPend <= 1'b0;
            end else begin
                if (w_sampleEdge) begin
                    r_rxShift <= {r_rxShift[DATA_W-2:0], w_mosiS};
                    if (w_lastBit) begin
                        r_bitCnt   <= '0;
                        r_wordDone <= 1'b1;
                        if (r_mode[0]) begin
                            r_txShift   <= w_txNext;
                            r_txReady   <= bus.tx_valid;
                            r_firstEdge <= 1'b1;
                        end else begin
                            r_reloadPend <= 1'b1;
                        end
                    end else begin
                        r_bitCnt <= r_bitCnt + CNT_W'(1);
                    end
                end
                if (w_shiftEdge) begin
                    if (r_mode[0] && r_firstEdge) begin
                        r_firstEdge <= 1'b0;
                    end else if (r_reloadPend) begin
                        r_txShift    <= w_txNext;
                        r_txReady    <= bus.tx_valid;
                        r_reloadPend <= 1'b0;
                    end else begin
                        r_txShift <= {r_txShift[DATA_W-2:0], 1'b1};
                    end
                end
            end
        end
    end

`ifdef SPI_OVERRUN_DETECT_EN
    logic w_overrunEvt, r_overrun;

    assign w_overrunEvt = r_wordDone && r_rxValid && !bus.rx_ready;
    assign w_rxAccept   = !w_overrunEvt;

    // Sticky until reset: software must notice a lost word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_overrun <= 1'b0;
        else if (w_overrunEvt)
            r_overrun <= 1'b1;
    end

    assign overrun = r_overrun;
`else
    assign w_rxAccept = 1'b1;
    assign overrun    = 1'b0;
`endif

    // Receive holding register. A completion in the same cycle as rx_ready
    // replaces the accepted word, so rx_valid simply stays high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rxData  <= '0;
            r_rxValid <= 1'b0;
        end else if (r_wordDone) begin
            if (w_rxAccept) begin
                r_rxData  <= r_rxShift;
                r_rxValid <= 1'b1;
            end
        end else if (r_rxValid && bus.rx_ready) begin
            r_rxValid <= 1'b0;
        end
    end

    assign miso         = r_txShift[DATA_W-1];
    assign frame_abort  = r_frameAbort;
    assign bus.tx_ready = r_txReady;
    assign bus.rx_data  = r_rxData;
    assign bus.rx_valid = r_rxValid;

endmodule

// File: tb/tb_spi_slave_xfer.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_xfer
// Directed bench for spi_slave_xfer: a 32-bit instance for the mode 0 word
// test and an 8-bit instance for everything else. Both share sclk/mosi and
// have separate ss_n pins. Build option SPI_OVERRUN_DETECT_EN selects the
// expected overrun behaviour.
// ---------------------------------------------------------------------------
module tb_spi_slave_xfer;
    import spi_pkg::*;

    localparam int HALF = 6;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       sclk, mosi, ss8_n, ss32_n;
    logic [1:0] mode;
    logic       miso8, miso32, oeb8, oeb32, busy8, busy32;
    logic       abort8, abort32, ovr8, ovr32;
    logic       sel32;

    int errors = 0;
    int checks = 0;
    int txRdy8 = 0, txRdy32 = 0, abort8Cnt = 0, abort32Cnt = 0;
    logic [7:0] rxQ8[$];

    spi_slave_xfer_if #(.DATA_W(8))  bus8 ();
    spi_slave_xfer_if #(.DATA_W(32)) bus32 ();

    spi_slave_xfer #(.DATA_W(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .sclk(sclk), .ss_n(ss8_n),
        .mosi(mosi), .miso(miso8), .miso_oeb(oeb8), .mode(mode),
        .bus(bus8), .busy(busy8), .frame_abort(abort8), .overrun(ovr8));

    spi_slave_xfer #(.DATA_W(32)) dut32 (
        .clock(clock), .reset_n(reset_n), .sclk(sclk), .ss_n(ss32_n),
        .mosi(mosi), .miso(miso32), .miso_oeb(oeb32), .mode(mode),
        .bus(bus32), .busy(busy32), .frame_abort(abort32), .overrun(ovr32));

    always #5 clock = ~clock;

    // Pulse counters and received-word log, sampled away from the active edge.
    always @(negedge clock) begin
        if (bus8.tx_ready)  txRdy8++;
        if (bus32.tx_ready) txRdy32++;
        if (abort8)         abort8Cnt++;
        if (abort32)        abort32Cnt++;
        if (bus8.rx_valid && bus8.rx_ready) rxQ8.push_back(bus8.rx_data);
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Park sclk at the mode's idle level, then select the chosen slave.
    task automatic frameStart();
        sclk = mode[1];
        waitClk(6);
        if (sel32) ss32_n = 1'b0;
        else       ss8_n  = 1'b0;
        waitClk(2 * HALF);
    endtask

    task automatic frameEnd();
        waitClk(HALF);
        ss8_n  = 1'b1;
        ss32_n = 1'b1;
        waitClk(8);
    endtask

    // Bit-banged SPI master; optionally checks rx_valid latency on the
    // final sample edge (CPHA=0 only, rx_ready must be low).
    task automatic spiWord(input int nbits, input logic [31:0] txw,
                           output logic [31:0] rxw, input bit latChk);
        logic cpol, cpha, v;
        cpol = mode[1];
        cpha = mode[0];
        rxw  = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi = txw[i];
                waitClk(HALF);
                rxw  = {rxw[30:0], (sel32 ? miso32 : miso8)};
                sclk = ~cpol;
                if (latChk && i == 0) begin
                    waitClk(3);
                    v = sel32 ? bus32.rx_valid : bus8.rx_valid;
                    checks++;
                    if (v !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL latency_early: rx_valid=%b want 0", v);
                    end
                    waitClk(1);
                    v = sel32 ? bus32.rx_valid : bus8.rx_valid;
                    checks++;
                    if (v !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL latency_on_time: rx_valid=%b want 1", v);
                    end
                    waitClk(HALF - 4);
                end else begin
                    waitClk(HALF);
                end
                sclk = cpol;
            end else begin
                waitClk(HALF);
                sclk = ~cpol;
                mosi = txw[i];
                waitClk(HALF);
                rxw  = {rxw[30:0], (sel32 ? miso32 : miso8)};
                sclk = cpol;
            end
        end
        waitClk(HALF);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sclk = 1'b0; mosi = 1'b0; ss8_n = 1'b1; ss32_n = 1'b1;
        mode = MODE0; sel32 = 1'b0;
        bus8.tx_data = '0;  bus8.tx_valid = 1'b0;  bus8.rx_ready = 1'b0;
        bus32.tx_data = '0; bus32.tx_valid = 1'b0; bus32.rx_ready = 1'b0;
        waitClk(3);
        checks++;
        if ({busy8, oeb8, miso8, bus8.rx_valid, bus8.tx_ready, abort8, ovr8} !== 7'b0110000) begin
            errors++;
            $display("[TB] FAIL reset8_flags: got %b want 0110000",
                     {busy8, oeb8, miso8, bus8.rx_valid, bus8.tx_ready, abort8, ovr8});
        end
        checks++;
        if ({busy32, oeb32, miso32, bus32.rx_valid, bus32.tx_ready, abort32, ovr32} !== 7'b0110000) begin
            errors++;
            $display("[TB] FAIL reset32_flags: got %b want 0110000",
                     {busy32, oeb32, miso32, bus32.rx_valid, bus32.tx_ready, abort32, ovr32});
        end
        checks++;
        if (bus32.rx_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rx_data: got %h want 00000000", bus32.rx_data);
        end
        reset_n = 1'b1;
        waitClk(5);
    endtask

    task automatic test_mode0_32();
        logic [31:0] got;
        int t0;
        sel32 = 1'b1; mode = MODE0;
        bus32.tx_data = 32'hA5A5_0F0F; bus32.tx_valid = 1'b1; bus32.rx_ready = 1'b0;
        t0 = txRdy32;
        frameStart();
        bus32.tx_valid = 1'b0;
        checks++;
        if ({busy32, oeb32} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL m0_active: busy/oeb=%b want 10", {busy32, oeb32});
        end
        spiWord(32, 32'hDEAD_BEEF, got, 1'b1);
        frameEnd();
        checks++;
        if (bus32.rx_data !== 32'hDEAD_BEEF || bus32.rx_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL m0_rx: got %h/%b want deadbeef/1", bus32.rx_data, bus32.rx_valid);
        end
        checks++;
        if (got !== 32'hA5A5_0F0F) begin
            errors++;
            $display("[TB] FAIL m0_miso: got %h want a5a50f0f", got);
        end
        checks++;
        if (txRdy32 - t0 !== 1) begin
            errors++;
            $display("[TB] FAIL m0_tx_ready: got %0d pulses want 1", txRdy32 - t0);
        end
        checks++;
        if (abort32Cnt !== 0) begin
            errors++;
            $display("[TB] FAIL m0_no_abort: got %0d want 0", abort32Cnt);
        end
        bus32.rx_ready = 1'b1;
        waitClk(1);
        bus32.rx_ready = 1'b0;
        checks++;
        if (bus32.rx_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL m0_handshake: rx_valid=%b want 0", bus32.rx_valid);
        end
        sel32 = 1'b0;
    endtask

    task automatic test_modes_8();
        logic [1:0] modes[3];
        logic [31:0] got;
        int t0;
        modes = '{MODE1, MODE2, MODE3};
        for (int m = 0; m < 3; m++) begin
            mode = modes[m];
            bus8.tx_data = 8'hC3; bus8.tx_valid = 1'b1; bus8.rx_ready = 1'b0;
            t0 = txRdy8;
            frameStart();
            bus8.tx_valid = 1'b0;
            spiWord(8, 32'h3C, got, 1'b0);
            frameEnd();
            checks++;
            if (bus8.rx_data !== 8'h3C || bus8.rx_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mode%0d_rx: got %h/%b want 3c/1", mode, bus8.rx_data, bus8.rx_valid);
            end
            checks++;
            if (got[7:0] !== 8'hC3) begin
                errors++;
                $display("[TB] FAIL mode%0d_miso: got %h want c3", mode, got[7:0]);
            end
            checks++;
            if (txRdy8 - t0 !== 1) begin
                errors++;
                $display("[TB] FAIL mode%0d_tx_ready: got %0d want 1", mode, txRdy8 - t0);
            end
            bus8.rx_ready = 1'b1;
            waitClk(1);
            bus8.rx_ready = 1'b0;
            checks++;
            if (bus8.rx_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mode%0d_handshake: rx_valid=%b want 0", mode, bus8.rx_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got1, got2;
        mode = MODE0;
        rxQ8.delete();
        bus8.tx_data = 8'h5A; bus8.tx_valid = 1'b1; bus8.rx_ready = 1'b1;
        frameStart();
        bus8.tx_valid = 1'b0;
        spiWord(8, 32'h12, got1, 1'b0);
        spiWord(8, 32'h34, got2, 1'b0);
        frameEnd();
        bus8.rx_ready = 1'b0;
        checks++;
        if (got1[7:0] !== 8'h5A || got2[7:0] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL b2b_miso: got %h %h want 5a ff", got1[7:0], got2[7:0]);
        end
        checks++;
        if (rxQ8.size() !== 2) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d words want 2", rxQ8.size());
        end else begin
            checks++;
            if (rxQ8[0] !== 8'h12 || rxQ8[1] !== 8'h34) begin
                errors++;
                $display("[TB] FAIL b2b_words: got %h %h want 12 34", rxQ8[0], rxQ8[1]);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] got;
        int a0;
        mode = MODE0;
        bus8.tx_valid = 1'b0; bus8.rx_ready = 1'b0;
        a0 = abort8Cnt;
        frameStart();
        spiWord(5, 32'h15, got, 1'b0);
        frameEnd();
        checks++;
        if (abort8Cnt - a0 !== 1 || bus8.rx_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_pulse: pulses=%0d rx_valid=%b want 1/0", abort8Cnt - a0, bus8.rx_valid);
        end
        checks++;
        if ({busy8, oeb8} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL abort_idle: busy/oeb=%b want 01", {busy8, oeb8});
        end
        frameStart();
        spiWord(8, 32'h81, got, 1'b0);
        frameEnd();
        checks++;
        if (bus8.rx_data !== 8'h81 || bus8.rx_valid !== 1'b1 || abort8Cnt - a0 !== 1) begin
            errors++;
            $display("[TB] FAIL abort_recover: got %h/%b pulses=%0d want 81/1/1",
                     bus8.rx_data, bus8.rx_valid, abort8Cnt - a0);
        end
        bus8.rx_ready = 1'b1;
        waitClk(1);
        bus8.rx_ready = 1'b0;
    endtask

    task automatic test_overrun();
        logic [31:0] got;
        logic [7:0]  expData;
        logic        expOvr;
`ifdef SPI_OVERRUN_DETECT_EN
        expData = 8'h11; expOvr = 1'b1;
`else
        expData = 8'h22; expOvr = 1'b0;
`endif
        mode = MODE0;
        bus8.tx_valid = 1'b0; bus8.rx_ready = 1'b0;
        frameStart();
        spiWord(8, 32'h11, got, 1'b0);
        spiWord(8, 32'h22, got, 1'b0);
        frameEnd();
        checks++;
        if (bus8.rx_data !== expData || ovr8 !== expOvr || bus8.rx_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun: got %h/%b/%b want %h/%b/1",
                     bus8.rx_data, ovr8, bus8.rx_valid, expData, expOvr);
        end
        bus8.rx_ready = 1'b1;
        waitClk(1);
        bus8.rx_ready = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] got;
        mode = MODE0;
        bus8.tx_data = 8'h00; bus8.tx_valid = 1'b1;
        frameStart();
        bus8.tx_valid = 1'b0;
        spiWord(3, 32'h5, got, 1'b0);
        checks++;
        if ({busy8, oeb8, miso8} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL mid_active: busy/oeb/miso=%b want 100", {busy8, oeb8, miso8});
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy8, oeb8, miso8, bus8.rx_valid, bus8.tx_ready, abort8, ovr8} !== 7'b0110000
            || bus8.rx_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL mid_reset: flags=%b rx_data=%h want 0110000/00",
                     {busy8, oeb8, miso8, bus8.rx_valid, bus8.tx_ready, abort8, ovr8}, bus8.rx_data);
        end
        ss8_n = 1'b1;
        sclk  = 1'b0;
        waitClk(2);
        reset_n = 1'b1;
        waitClk(4);
    endtask

    initial begin
        test_reset();
        test_mode0_32();
        test_modes_8();
        test_back_to_back();
        test_abort();
        test_overrun();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_xfer.md
Name: spi_slave_xfer

Overview:
Parametrised full-duplex SPI slave for the user-project SPI path. It oversamples sclk/ss_n/mosi in the system clock domain and supports all four SPI modes. Word width is configurable. Received words leave through a valid/ready stream and transmit words enter through a second valid/ready stream. It replaces the fixed 32-bit mode-0 receive-only shifter and adds MISO transmit, frame abort and receive handshake.

Parameters:
DATA_W, 32, bits per SPI word (min 4).
SYNC_STAGES, 2, synchroniser flops per SPI input (min 2).
TX_IDLE, {DATA_W{1'b1}}, word shifted out when no tx word is pending.

Ports:
clock  in  1  system clock; all logic on posedge.
reset_n  in  1  asynchronous active-low reset.
sclk  in  1  SPI clock pin (async).
ss_n  in  1  SPI select, active-low (async).
mosi  in  1  SPI data in (async).
miso  out  1  SPI data out = tx_shift[DATA_W-1].
miso_oeb  out  1  0 while selected (ACTIVE), else 1.
mode  in  2  {CPOL,CPHA}; captured at frame start.
tx_data  in  DATA_W  next word to transmit.
tx_valid  in  1  tx_data valid.
tx_ready  out  1  one-cycle pulse: tx_data consumed.
rx_data  out  DATA_W  last received word; stable while rx_valid.
rx_valid  out  1  rx_data valid; held until rx_ready.
rx_ready  in  1  consumer accepts rx_data.
busy  out  1  state == ACTIVE.
frame_abort  out  1  one-cycle pulse: ss_n rose mid-word.
overrun  out  1  sticky overrun flag (see Optional Feature).

Behaviour:
- Reset values: state IDLE, bit_cnt 0, tx_shift TX_IDLE, rx_data 0, rx_valid 0, tx_ready 0, busy 0, frame_abort 0, overrun 0, miso_oeb 1. All synchroniser flops reset to 1 for ss_n and 0 for sclk/mosi.
- Each input passes through SYNC_STAGES flops, then one history flop. Edges are decoded from the last two synced samples.
- Leading edge: rising if CPOL=0, falling if CPOL=1. Sample edge: leading if CPHA=0, else trailing. Shift edge: the other edge.
- IDLE -> ACTIVE on a synced ss_n falling edge:
  - Latch mode and clear bit_cnt.
  - Load tx_shift: if tx_valid, take tx_data and pulse tx_ready; otherwise load TX_IDLE.
  - Set first_edge=1.
- ACTIVE, on a sample edge:
  - rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}; bit_cnt++.
  - At bit_cnt==DATA_W-1: complete the word (see rx rules), bit_cnt <= 0.
- ACTIVE, on a shift edge: tx_shift shifts left with 1 filled in. Exceptions:
  - CPHA=1 with first_edge set: no shift; clear first_edge.
  - The shift edge after word completion (CPHA=0), or the completing sample edge itself (CPHA=1): reload tx_shift (same tx_valid/TX_IDLE rule, tx_ready pulse). For CPHA=1 also set first_edge.
- ACTIVE -> IDLE on a synced ss_n rising edge:
  - Discard the partial word and clear bit_cnt.
  - Pulse frame_abort only if bit_cnt != 0.
  - miso_oeb <= 1 on the same cycle.
- rx rules:
  - On completion, rx_data <= assembled word and rx_valid <= 1 on the following clock edge. Latency from the final sample edge at the pin to rx_valid is SYNC_STAGES+2 clocks.
  - The rx_valid && rx_ready handshake clears rx_valid.
  - If completion and rx_ready arrive on the same cycle: the old word is accepted, the new word is loaded, rx_valid stays 1, no overrun.
  - Completion while rx_valid && !rx_ready is an overrun; handling is defined under Optional Feature.
- mode changes during ACTIVE are ignored until the next frame.
- An sclk edge on the same cycle as an ss_n rising edge is ignored.
- Async reset mid-frame returns every signal to its reset value immediately. The master must restart the frame.

Optional Feature:
SPI_OVERRUN_DETECT_EN
- Defined: on overrun, the new word is dropped, rx_data keeps the old word, and overrun is set sticky until reset_n.
- Undefined: on overrun, the new word overwrites rx_data, rx_valid stays 1, and the overrun port is tied 0.

Decomposition:
- Package spi_pkg holds:
  - localparam encodings MODE0..MODE3;
  - state enum {IDLE, ACTIVE};
  - helper function lead_is_rise(cpol).
- One sub-module, spi_sync (N-stage reset-valued synchroniser, parameters STAGES and RST_VAL), instantiated three times.

Test Plan:
- Mode 0, DATA_W=32, tx_data=32'hA5A5_0F0F preloaded, master sends 32'hDEAD_BEEF -> rx_data=32'hDEADBEEF with rx_valid; miso carries A5A50F0F MSB-first; tx_ready pulses once.
- Modes 1, 2, 3, DATA_W=8, master sends 8'h3C with tx 8'hC3 -> rx_data=8'h3C and master receives 8'hC3 in every mode.
- Two back-to-back words in one frame, tx_valid low for the second -> second miso word is TX_IDLE (8'hFF); two rx_valid words.
- ss_n raised after 5 of 8 bits -> frame_abort pulses once, rx_valid stays 0, next frame receives 8'h81 correctly.
- rx_ready held 0 across two words 8'h11, 8'h22 -> with macro: rx_data=8'h11, overrun=1; without macro: rx_data=8'h22, overrun=0.
- reset_n asserted at bit 3 -> all outputs at reset values within the same cycle; miso_oeb=1, busy=0.
